// File: rtl/memref_mp.sv
// Multi-port memory model: NUM_RD read / NUM_WR write ports on one array, RD_LAT-deep read pipeline,
// sticky conflict/out-of-range flags. Per-port access counters exist only when MEMREF_STATS_EN is defined.
module memref_mp #(
  parameter int WIDTH       = 32,
  parameter int SIZE        = 1024,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 1,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 0,
  parameter     INIT_FILE   = "",
  localparam int ADDR_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic                     err_clr,
  output logic                     conflict_err,
  output logic                     oob_err,
  output logic [NUM_RD*32-1:0]     rd_count,
  output logic [NUM_WR*32-1:0]     wr_count
);

  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W+1)'(SIZE);

  logic [WIDTH-1:0]  r_mem [SIZE];
  logic [NUM_WR-1:0] w_wr_oob;
  logic [NUM_WR-1:0] w_wr_dup;
  logic [NUM_WR-1:0] w_wr_commit;
  logic [NUM_RD-1:0] w_rd_oob;
  logic              w_conflict;
  logic              w_oob_any;
  logic              r_conflict_err;
  logic              r_oob_err;

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_oob
      assign w_wr_oob[gi] = {1'b0, wr_addr[gi*ADDR_W +: ADDR_W]} >= SIZE_L;
    end
  endgenerate

  // A writer is a duplicate if any lower-index enabled writer targets the same address.
  always_comb begin
    w_wr_dup   = '0;
    w_conflict = 1'b0;
    for (int v = 1; v < NUM_WR; v++) begin
      for (int u = 0; u < v; u++) begin
        if (wr_en[u] && wr_en[v] &&
            wr_addr[u*ADDR_W +: ADDR_W] == wr_addr[v*ADDR_W +: ADDR_W]) begin
          w_wr_dup[v] = 1'b1;
          w_conflict  = 1'b1;
        end
      end
    end
  end

  assign w_wr_commit = wr_en & ~w_wr_oob & ~w_wr_dup;
  assign w_oob_any   = (|(rd_en & w_rd_oob)) | (|(wr_en & w_wr_oob));

  // Committing writers never share an address, so loop order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (w_wr_commit[w]) begin
          r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [WIDTH-1:0]  w_word;
      logic              r_vld  [RD_LAT];
      logic [WIDTH-1:0]  r_data [RD_LAT];

      assign w_addr       = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_rd_oob[gi] = {1'b0, w_addr} >= SIZE_L;

      always_comb begin
        w_word = '0;
        if (!w_rd_oob[gi]) begin
          w_word = r_mem[w_addr];
          if (WRITE_FIRST != 0) begin
            for (int w = 0; w < NUM_WR; w++) begin
              if (w_wr_commit[w] && wr_addr[w*ADDR_W +: ADDR_W] == w_addr) begin
                w_word = wr_data[w*WIDTH +: WIDTH];
              end
            end
          end
        end
      end

      // Data stages only load when a valid word moves in, so the output holds between results.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < RD_LAT; s++) begin
            r_vld[s]  <= 1'b0;
            r_data[s] <= '0;
          end
        end else begin
          r_vld[0] <= rd_en[gi];
          if (rd_en[gi]) begin
            r_data[0] <= w_word;
          end
          for (int s = 1; s < RD_LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            if (r_vld[s-1]) begin
              r_data[s] <= r_data[s-1];
            end
          end
        end
      end

      assign rd_valid[gi]                = r_vld[RD_LAT-1];
      assign rd_data[gi*WIDTH +: WIDTH] = r_data[RD_LAT-1];
    end
  endgenerate

  // New errors take priority over a clear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_err <= 1'b0;
      r_oob_err      <= 1'b0;
    end else begin
      r_conflict_err <= w_conflict | (r_conflict_err & ~err_clr);
      r_oob_err      <= w_oob_any  | (r_oob_err & ~err_clr);
    end
  end

  assign conflict_err = r_conflict_err;
  assign oob_err      = r_oob_err;

`ifdef MEMREF_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_cnt
      logic [31:0] r_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_cnt <= '0;
        else if (err_clr)    r_cnt <= '0;
        else if (rd_en[gi])  r_cnt <= r_cnt + 32'd1;
      end
      assign rd_count[gi*32 +: 32] = r_cnt;
    end
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_cnt
      logic [31:0] r_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_cnt <= '0;
        else if (err_clr)          r_cnt <= '0;
        else if (w_wr_commit[gi])  r_cnt <= r_cnt + 32'd1;
      end
      assign wr_count[gi*32 +: 32] = r_cnt;
    end
  endgenerate
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
